// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register file geometry and write-back scheduler enums.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_PIPE, WB_SRC_LL} wb_src_e;
  typedef enum logic {HOLD_IDLE, HOLD_ACTIVE} hold_state_e;

endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// reg_scoreboard: pending bit per architectural register for in-flight long-latency ops.
// x0 can never be pending; a set and a clear of the same register in one cycle leaves it pending.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] lk_a_idx,
  input  logic [REG_ADDR_W-1:0] lk_b_idx,
  input  logic [REG_ADDR_W-1:0] lk_c_idx,
  output logic                  lk_a_hit,
  output logic                  lk_b_hit,
  output logic                  lk_c_hit
);

  logic [NUM_REGS-1:1] pending_q;
  logic [NUM_REGS-1:0] pending;

  // Set is checked before clear so a freshly issued op keeps its register pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_idx == REG_ADDR_W'(i)) begin
          pending_q[i] <= 1'b1;
        end else if (clr_en && clr_idx == REG_ADDR_W'(i)) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  assign pending  = {pending_q, 1'b0};
  assign lk_a_hit = pending[lk_a_idx];
  assign lk_b_hit = pending[lk_b_idx];
  assign lk_c_hit = pending[lk_c_idx];

endmodule

// File: rtl/regfile_wb_sched.sv
// Register file write-port scheduler: pipeline WB has priority, LLU results fill idle slots.
// Define REGFILE_WB_PERF_EN to build the saturating perf_conflict counter.
module regfile_wb_sched
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]       pipe_wb_data,
  input  logic                  ll_issue_valid,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  input  logic                  ll_wb_valid,
  output logic                  ll_wb_ready,
  input  logic [REG_ADDR_W-1:0] ll_wb_rd,
  input  logic [XLEN-1:0]       ll_wb_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  sb_hazard,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      perf_conflict
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        pipe_write;
  logic        ll_hs;
  wb_src_e     wb_src;
  logic [3:0]  starve_cnt;
  hold_state_e state_q, state_d;
  logic        hit_rs1, hit_rs2, hit_rd;

  // A pipeline write to x0 is a bubble, so the LLU may take the port that cycle.
  assign pipe_write  = pipe_wb_valid && (pipe_wb_rd != '0) && !rst;
  assign ll_hs       = ll_wb_valid && !pipe_write && !rst;
  assign ll_wb_ready = ll_hs;

  always_comb begin
    wb_src = WB_SRC_NONE;
    if (pipe_write) begin
      wb_src = WB_SRC_PIPE;
    end else if (ll_hs) begin
      wb_src = WB_SRC_LL;
    end
  end

  // An LLU result for x0 still completes its handshake but never writes.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    case (wb_src)
      WB_SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_rd    = pipe_wb_rd;
        rf_wdata = pipe_wb_data;
      end
      WB_SRC_LL: begin
        rf_we    = (ll_wb_rd != '0);
        rf_rd    = ll_wb_rd;
        rf_wdata = ll_wb_data;
      end
      default: ;
    endcase
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (ll_issue_valid),
    .set_idx  (ll_issue_rd),
    .clr_en   (ll_hs),
    .clr_idx  (ll_wb_rd),
    .lk_a_idx (chk_rs1),
    .lk_b_idx (chk_rs2),
    .lk_c_idx (chk_rd),
    .lk_a_hit (hit_rs1),
    .lk_b_hit (hit_rs2),
    .lk_c_hit (hit_rd)
  );

  assign sb_hazard = hit_rs1 | hit_rs2 | hit_rd;

  always_ff @(posedge clk) begin
    if (rst || ll_hs) begin
      starve_cnt <= 4'd0;
    end else if (ll_wb_valid && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold is only raised if the starved result is still waiting this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD_IDLE:   if (starve_cnt == LIMIT && !ll_hs) state_d = HOLD_ACTIVE;
      HOLD_ACTIVE: if (ll_hs) state_d = HOLD_IDLE;
      default:     state_d = HOLD_IDLE;
    endcase
  end

  assign pipe_hold = (state_q == HOLD_ACTIVE);

`ifdef REGFILE_WB_PERF_EN
  logic [CNT_W-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (ll_wb_valid && pipe_write && perf_q != '1) begin
      perf_q <= perf_q + CNT_W'(1);
    end
  end

  assign perf_conflict = perf_q;
`else
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed-vector bench for regfile_wb_sched: port arbitration, scoreboard, starvation hold, reset.
module tb_regfile_wb_sched;
  import riscv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pipe_wb_valid;
  logic [REG_ADDR_W-1:0] pipe_wb_rd;
  logic [XLEN-1:0]       pipe_wb_data;
  logic                  ll_issue_valid;
  logic [REG_ADDR_W-1:0] ll_issue_rd;
  logic                  ll_wb_valid;
  logic                  ll_wb_ready;
  logic [REG_ADDR_W-1:0] ll_wb_rd;
  logic [XLEN-1:0]       ll_wb_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wdata;
  logic [REG_ADDR_W-1:0] chk_rs1, chk_rs2, chk_rd;
  logic                  sb_hazard;
  logic                  pipe_hold;
  logic [15:0]           perf_conflict;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_wb_valid  (pipe_wb_valid),
    .pipe_wb_rd     (pipe_wb_rd),
    .pipe_wb_data   (pipe_wb_data),
    .ll_issue_valid (ll_issue_valid),
    .ll_issue_rd    (ll_issue_rd),
    .ll_wb_valid    (ll_wb_valid),
    .ll_wb_ready    (ll_wb_ready),
    .ll_wb_rd       (ll_wb_rd),
    .ll_wb_data     (ll_wb_data),
    .rf_we          (rf_we),
    .rf_rd          (rf_rd),
    .rf_wdata       (rf_wdata),
    .chk_rs1        (chk_rs1),
    .chk_rs2        (chk_rs2),
    .chk_rd         (chk_rd),
    .sb_hazard      (sb_hazard),
    .pipe_hold      (pipe_hold),
    .perf_conflict  (perf_conflict)
  );

  // Advance one rising edge, then leave 1 time unit before driving new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wb_valid  = 1'b0;
    pipe_wb_rd     = '0;
    pipe_wb_data   = '0;
    ll_issue_valid = 1'b0;
    ll_issue_rd    = '0;
    ll_wb_valid    = 1'b0;
    ll_wb_rd       = '0;
    ll_wb_data     = '0;
    chk_rs1        = '0;
    chk_rs2        = '0;
    chk_rd         = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'h1111;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd7;
    #1;
    vectors++;
    if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_we: got %b expected 0", rf_we); end
    vectors++;
    if (ll_wb_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", ll_wb_ready); end
    tick();
    rst = 1'b0;
    idle_inputs();
    chk_rs1 = 5'd1; chk_rs2 = 5'd5; chk_rd = 5'd31;
    #1;
    vectors++;
    if (pipe_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hold: got %b expected 0", pipe_hold); end
    vectors++;
    if (sb_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hazard: got %b expected 0", sb_hazard); end
    vectors++;
    if (perf_conflict !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_perf: got %0d expected 0", perf_conflict); end
    idle_inputs();
  endtask

  task automatic test_collision();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hAAAA;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd7; ll_wb_data = 32'h1234;
    #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata, ll_wb_ready} !== {1'b1, 5'd5, 32'hAAAA, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL collision_pipe: got we=%b rd=%0d data=%h rdy=%b expected we=1 rd=5 data=0000aaaa rdy=0",
               rf_we, rf_rd, rf_wdata, ll_wb_ready);
    end
    tick();
    pipe_wb_valid = 1'b0;
    #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata, ll_wb_ready} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL collision_ll: got we=%b rd=%0d data=%h rdy=%b expected we=1 rd=7 data=00001234 rdy=1",
               rf_we, rf_rd, rf_wdata, ll_wb_ready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_issue_clear();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd9;
    tick();
    ll_issue_valid = 1'b0;
    chk_rs2 = 5'd9;
    #1;
    vectors++;
    if (sb_hazard !== 1'b1) begin miscompares++; $display("[TB] FAIL issue9_hazard: got %b expected 1", sb_hazard); end
    chk_rs2 = 5'd10;
    #1;
    vectors++;
    if (sb_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL issue9_other_reg: got %b expected 0", sb_hazard); end
    chk_rs2 = 5'd9;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd9; ll_wb_data = 32'h99;
    #1;
    vectors++;
    if (ll_wb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL clear9_ready: got %b expected 1", ll_wb_ready); end
    tick();
    ll_wb_valid = 1'b0;
    #1;
    vectors++;
    if (sb_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL clear9_hazard: got %b expected 0", sb_hazard); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd3;
    tick();
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd3; ll_wb_data = 32'h33;
    tick();
    ll_issue_valid = 1'b0; ll_wb_valid = 1'b0;
    chk_rd = 5'd3;
    #1;
    vectors++;
    if (sb_hazard !== 1'b1) begin miscompares++; $display("[TB] FAIL setclr3_hazard: got %b expected 1", sb_hazard); end
    ll_wb_valid = 1'b1;
    tick();
    ll_wb_valid = 1'b0;
    #1;
    vectors++;
    if (sb_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL clear3_hazard: got %b expected 0", sb_hazard); end
    idle_inputs();
  endtask

  task automatic test_x0();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd0;
    tick();
    ll_issue_valid = 1'b0;
    #1;
    vectors++;
    if (sb_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_hazard: got %b expected 0", sb_hazard); end
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'h5555;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd12; ll_wb_data = 32'hBEEF;
    #1;
    vectors++;
    if ({rf_we, rf_rd, rf_wdata, ll_wb_ready} !== {1'b1, 5'd12, 32'hBEEF, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL x0_pipe_bubble: got we=%b rd=%0d data=%h rdy=%b expected we=1 rd=12 data=0000beef rdy=1",
               rf_we, rf_rd, rf_wdata, ll_wb_ready);
    end
    tick();
    pipe_wb_valid = 1'b0;
    ll_wb_rd = 5'd0; ll_wb_data = 32'h7777;
    #1;
    vectors++;
    if ({rf_we, ll_wb_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL x0_ll_write: got we=%b rdy=%b expected we=0 rdy=1", rf_we, ll_wb_ready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd1; pipe_wb_data = 32'h1;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd2; ll_wb_data = 32'h2;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (pipe_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL starve_hold_early: got %b expected 0", pipe_hold); end
    tick();
    vectors++;
    if (pipe_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_hold_set: got %b expected 1", pipe_hold); end
    tick();
    vectors++;
    if (pipe_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_hold_kept: got %b expected 1", pipe_hold); end
    pipe_wb_valid = 1'b0;
    #1;
    vectors++;
    if ({ll_wb_ready, rf_rd} !== {1'b1, 5'd2}) begin
      miscompares++;
      $display("[TB] FAIL starve_release: got rdy=%b rd=%0d expected rdy=1 rd=2", ll_wb_ready, rf_rd);
    end
    tick();
    ll_wb_valid = 1'b0;
    vectors++;
    if (pipe_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL starve_hold_clear: got %b expected 0", pipe_hold); end
    idle_inputs();
  endtask

  task automatic test_midstream_reset();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd4;
    tick();
    ll_issue_rd = 5'd12;
    tick();
    ll_issue_valid = 1'b0;
    chk_rs1 = 5'd4; chk_rs2 = 5'd12;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd1; pipe_wb_data = 32'h1;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd20; ll_wb_data = 32'h20;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if ({sb_hazard, pipe_hold} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL prereset_state: got hazard=%b hold=%b expected hazard=1 hold=1", sb_hazard, pipe_hold);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({rf_we, ll_wb_ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midreset_port: got we=%b rdy=%b expected we=0 rdy=0", rf_we, ll_wb_ready);
    end
    tick();
    rst = 1'b0;
    pipe_wb_valid = 1'b0; ll_wb_valid = 1'b0;
    chk_rd = 5'd12;
    #1;
    vectors++;
    if ({sb_hazard, pipe_hold} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got hazard=%b hold=%b expected hazard=0 hold=0", sb_hazard, pipe_hold);
    end
    vectors++;
    if (perf_conflict !== 16'd0) begin miscompares++; $display("[TB] FAIL midreset_perf: got %0d expected 0", perf_conflict); end
    idle_inputs();
  endtask

  task automatic test_perf();
    logic [15:0] exp_perf;
`ifdef REGFILE_WB_PERF_EN
    exp_perf = 16'd3;
`else
    exp_perf = 16'd0;
`endif
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd6; pipe_wb_data = 32'h6;
    ll_wb_valid = 1'b1; ll_wb_rd = 5'd8; ll_wb_data = 32'h8;
    for (int i = 0; i < 3; i++) tick();
    pipe_wb_valid = 1'b0;
    tick();
    ll_wb_valid = 1'b0;
    tick();
    vectors++;
    if (perf_conflict !== exp_perf) begin
      miscompares++;
      $display("[TB] FAIL perf_conflict: got %0d expected %0d", perf_conflict, exp_perf);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_collision();
    test_issue_clear();
    test_same_cycle();
    test_x0();
    test_starvation();
    test_midstream_reset();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
